// File: rtl/des_perm_pipe.sv
// DES initial/final permutation pipeline with valid/ready handshaking and a sideband tag.
// Stage 1 registers the permuted block; later stages only add delay.
module des_perm_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [31:0]      l_out,
  output logic [31:0]      r_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("des_perm_pipe: STAGES must be in 1..4");
    end
    if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag_w
      $error("des_perm_pipe: TAG_W must be in 1..16");
    end
  endgenerate

  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        r[8*j+k]    = d[57+2*j-8*k];
        r[32+8*j+k] = d[56+2*j-8*k];
      end
    end
    return r;
  endfunction

  // Inverse mapping: scatter each IP output bit back to the input position it came from.
  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        r[57+2*j-8*k] = d[8*j+k];
        r[56+2*j-8*k] = d[32+8*j+k];
      end
    end
    return r;
  endfunction

  logic [STAGES-1:0] vld;
  logic [63:0]       data [STAGES];
  logic [TAG_W-1:0]  tag  [STAGES];

  logic [STAGES-1:0] load;
  logic              load_acc;
  logic [STAGES-1:0] src_vld;
  logic [63:0]       src_data [STAGES];
  logic [TAG_W-1:0]  src_tag  [STAGES];
  logic [63:0]       perm;
  logic              accept;

  assign perm = in_mode ? fp_perm(in_data) : ip_perm(in_data);

  // A stage may load when it, or any stage downstream of it, has room once the output drains.
  always_comb begin
    load_acc = out_ready;
    load     = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load_acc = load_acc | ~vld[i];
      load[i]  = load_acc;
    end
  end

  assign in_ready = load[0] & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    src_vld     = '0;
    src_vld[0]  = accept;
    src_data[0] = perm;
    src_tag[0]  = in_tag;
    for (int i = 1; i < STAGES; i++) begin
      src_vld[i]  = vld[i-1];
      src_data[i] = data[i-1];
      src_tag[i]  = tag[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          vld[i]  <= src_vld[i];
          data[i] <= src_data[i];
          tag[i]  <= src_tag[i];
        end
      end
      if (flush) begin
        vld <= '0;
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_data  = data[STAGES-1];
  assign out_tag   = tag[STAGES-1];
  assign l_out     = out_data[63:32];
  assign r_out     = out_data[31:0];
  assign busy      = |vld;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: hand-computed permutation vectors, latency,
// round trip, backpressure, flush and asynchronous reset.
module tb_des_perm_pipe;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;
  localparam int N      = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [63:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [31:0]      l_out;
  logic [31:0]      r_out;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] vec_in [5];
  logic [63:0] vec_ip [5];
  logic [63:0] src    [N];
  logic [63:0] res    [N];

  des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .l_out(l_out), .r_out(r_out), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  // Sends one block, then waits (bounded) for it and checks latency, data and tag.
  task automatic run_one(input logic [63:0] d, input logic m, input logic [TAG_W-1:0] t,
                         input logic [63:0] exp, input string name);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_tag   = t;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(STAGES));
    check({name, "_out_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, out_data, exp);
    check({name, "_tag"}, 64'(out_tag), 64'(t));
    check({name, "_l_out"}, 64'(l_out), 64'(exp[63:32]));
    check({name, "_r_out"}, 64'(r_out), 64'(exp[31:0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int acc;
    int got;
    vec_in[0] = 64'h0000_0000_0000_0001;  vec_ip[0] = 64'h0000_0080_0000_0000;
    vec_in[1] = 64'h8000_0000_0000_0000;  vec_ip[1] = 64'h0000_0000_0100_0000;
    vec_in[2] = 64'h0200_0000_0000_0000;  vec_ip[2] = 64'h0000_0000_0000_0001;
    vec_in[3] = 64'h0000_0000_0000_0040;  vec_ip[3] = 64'h8000_0000_0000_0000;
    vec_in[4] = 64'hFFFF_FFFF_FFFF_FFFF;  vec_ip[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < N; i++) src[i] = {$urandom, $urandom};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_data = '0; in_tag = '0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_l_out", 64'(l_out), 64'd0);
    check("rst_r_out", 64'(r_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);

    run_one(vec_in[0], 1'b0, 4'h1, vec_ip[0], "ip_bit0");
    run_one(vec_in[1], 1'b0, 4'h2, vec_ip[1], "ip_bit63");
    run_one(vec_ip[1], 1'b1, 4'h3, vec_in[1], "fp_bit24");
    run_one(vec_in[2], 1'b0, 4'h4, vec_ip[2], "ip_bit57");
    run_one(vec_in[3], 1'b0, 4'h5, vec_ip[3], "ip_bit6");
    run_one(vec_ip[2], 1'b1, 4'h6, vec_in[2], "fp_bit0");
    run_one(vec_ip[3], 1'b1, 4'h7, vec_in[3], "fp_bit63");
    run_one(vec_in[4], 1'b0, 4'h8, vec_ip[4], "ip_ones");

    // Full-rate stream through IP, then the results back through FP.
    for (int c = 0; c < N + STAGES; c++) begin
      @(negedge clk);
      if (c >= STAGES) begin
        check("rt_ip_valid", 64'(out_valid), 64'd1);
        check("rt_ip_tag", 64'(out_tag), 64'((c - STAGES) % 16));
        res[c-STAGES] = out_data;
      end
      if (c < N) begin
        in_valid = 1'b1; in_mode = 1'b0; in_data = src[c]; in_tag = 4'(c % 16);
        check("rt_ip_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    for (int c = 0; c < N + STAGES; c++) begin
      @(negedge clk);
      if (c >= STAGES) begin
        check("rt_fp_valid", 64'(out_valid), 64'd1);
        check("rt_fp_tag", 64'(out_tag), 64'((c - STAGES + 3) % 16));
        check("rt_fp_data", out_data, src[c-STAGES]);
      end
      if (c < N) begin
        in_valid = 1'b1; in_mode = 1'b1; in_data = res[c]; in_tag = 4'((c + 3) % 16);
        check("rt_fp_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: exactly STAGES blocks fit, outputs hold, then all five drain in order.
    @(negedge clk);
    out_ready = 1'b0;
    in_mode = 1'b0;
    check("stall_idle_busy", 64'(busy), 64'd0);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = vec_in[acc]; in_tag = 4'(8 + acc);
      #1;
      check("stall_in_ready", 64'(in_ready), 64'(i < STAGES));
      if (in_ready) acc++;
      @(negedge clk);
    end
    check("stall_accepted", 64'(acc), 64'(STAGES));
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_data", out_data, vec_ip[0]);
    repeat (3) @(negedge clk);
    check("stall_hold_valid", 64'(out_valid), 64'd1);
    check("stall_hold_data", out_data, vec_ip[0]);
    check("stall_hold_tag", 64'(out_tag), 64'd8);
    out_ready = 1'b1;
    got = 0;
    for (int it = 0; it < 30 && got < 5; it++) begin
      #1;
      if (out_valid) begin
        check("drain_data", out_data, vec_ip[got]);
        check("drain_tag", 64'(out_tag), 64'(8 + got));
        got++;
      end
      if (acc < 5) begin
        in_valid = 1'b1; in_data = vec_in[acc]; in_tag = 4'(8 + acc);
        if (in_ready) acc++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("drain_count", 64'(got), 64'd5);

    // Flush with two blocks in flight and a third offered.
    @(negedge clk);
    check("pre_flush_busy", 64'(busy), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = vec_in[0]; in_tag = 4'h1;
    @(negedge clk);
    in_data = vec_in[1]; in_tag = 4'h2;
    @(negedge clk);
    flush = 1'b1; in_data = vec_in[2]; in_tag = 4'h3;
    #1;
    check("flush_busy_before", 64'(busy), 64'd1);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    out_ready = 1'b1;
    repeat (STAGES + 1) begin
      @(negedge clk);
      check("flush_no_stale", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset between edges with the pipeline full.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      in_valid = 1'b1; in_data = vec_in[i]; in_tag = 4'(i + 1);
      #1;
      check("fill_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_out_data", out_data, 64'd0);
    check("arst_out_tag", 64'(out_tag), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("arst_release_ready", 64'(in_ready), 64'd1);
    check("arst_release_valid", 64'(out_valid), 64'd0);
    run_one(vec_in[3], 1'b0, 4'hC, vec_ip[3], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_perm_pipe.md
DES_PERM_PIPE -- requirements
Module: des_perm_pipe

Interface
REQ-001 Parameter STAGES, default 2: number of register stages, legal range 1..4; elaboration SHALL fail outside this range.
REQ-002 Parameter TAG_W, default 4: width of the sideband tag carried alongside each block, legal range 1..16.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear of all in-flight blocks.
REQ-006 in_valid  input  1  input block present.
REQ-007 in_ready  output  1  block accepted when in_valid and in_ready are both high on a clk edge.
REQ-008 in_mode  input  1  0 = initial permutation (IP), 1 = final permutation (FP = IP inverse).
REQ-009 in_data  input  64  input block.
REQ-010 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result when out_valid and out_ready are both high.
REQ-013 out_data  output  64  permuted block.
REQ-014 l_out  output  32  equals out_data[63:32].
REQ-015 r_out  output  32  equals out_data[31:0].
REQ-016 out_tag  output  TAG_W  tag of the presented result.
REQ-017 busy  output  1  high while any stage holds a valid block.

Function
REQ-018 IP: for j=0..3, k=0..7, out[8j+k] SHALL equal in[57+2j-8k], and out[32+8j+k] SHALL equal in[56+2j-8k].
REQ-019 FP: the exact inverse of IP, so that FP(IP(x)) = x and IP(FP(x)) = x for every 64-bit x.
REQ-020 Permutation: selected per block by in_mode, computed combinationally before stage 1 and registered in stage 1; stages 2..STAGES delay only.
REQ-021 Each stage: holds a valid bit, 64-bit data and tag; mode is not stored past stage 1.
REQ-022 Stage advance: a stage loads from its predecessor when it is empty or is being drained in the same cycle.
REQ-023 Last stage drain: occurs when out_valid and out_ready are both high.
REQ-024 in_ready: SHALL equal NOT stage1_valid OR stage1_advancing; a combinational path from out_ready to in_ready is permitted.
REQ-025 Throughput and latency: one block per cycle with out_ready held high; latency from acceptance edge to out_valid high is exactly STAGES cycles.
REQ-026 Backpressure: while out_valid is high and out_ready is low, out_data, out_tag and out_valid SHALL hold stable; no block is dropped or duplicated.
REQ-027 Ordering: blocks SHALL exit in acceptance order with their own tags and modes applied.
REQ-028 Buffering: with out_ready held low, the pipeline SHALL accept exactly STAGES blocks, then drive in_ready low.
REQ-029 flush: clears all valid bits at the next edge; in_ready SHALL be low in the flush cycle; a block offered in that cycle is not accepted.
REQ-030 flush priority: flush SHALL override simultaneous accept and drain; out_valid SHALL be low the cycle after.
REQ-031 Data and tag registers: not required to clear on flush, only the valid bits.
REQ-032 busy: SHALL equal the OR of all stage valid bits.

Reset
REQ-033 On rst high: all valid bits, out_data and out_tag SHALL clear to 0 immediately, without waiting for clk.
REQ-034 While rst is high: out_valid=0, busy=0, in_ready=0, l_out=0, r_out=0.
REQ-035 Reset release: in_ready SHALL rise combinationally once rst is low; the first accept is possible on the first clk edge after release.
REQ-036 Mid-stream reset: rst during operation SHALL discard all in-flight blocks; no stale block may appear after release.

Verification
REQ-037 STAGES=2, IP, in_data=64'h0000_0000_0000_0001, out_ready=1 -> after 2 cycles out_data=64'h0000_0080_0000_0000, l_out=32'h0000_0080, r_out=0.
REQ-038 IP, in_data=64'h8000_0000_0000_0000 -> out_data=64'h0000_0000_0100_0000; the same value sent with FP -> 64'h8000_0000_0000_0000.
REQ-039 Random round trip, 10k blocks: random in_data through IP, each result fed back with FP -> original data and tags in order, for STAGES=1..4.
REQ-040 STAGES=3, out_ready=0, 5 blocks offered -> 3 accepted, in_ready low; release out_ready -> all 5 exit in order; outputs stable during the stall.
REQ-041 Flush with 2 blocks in flight and in_valid high -> next cycle out_valid=0, busy=0; the offered block is not accepted.
REQ-042 Async reset asserted between clk edges with the pipeline full -> out_valid, busy and out_data go to 0 before the next edge; after release, the first accepted block is the first to exit.
